mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the CPU's instruction-fetch port and its data (load/store) port.
- Sits between the cpu core and the memory model. It serialises requests, arbitrates ties fairly and returns a one-cycle completion pulse to each requester.
- A watchdog aborts memory accesses that never complete and flags a bus error.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory port shared by the arbiter and its neighbours.
// The arbiter connects through the slave modport; the CPU/memory side uses master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iReq;
    logic [ADDR_W-1:0] instrAddr;
    logic [DATA_W-1:0] instr;
    logic              iValid;
    logic              dReq;
    logic [ADDR_W-1:0] dataAddr;
    logic [DATA_W-1:0] writeData;
    logic              we;
    logic [DATA_W-1:0] readData;
    logic              dValid;
    logic              memReq;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              memWe;
    logic              memReady;
    logic [DATA_W-1:0] memRdata;
    logic              busErr;
    logic              errSticky;

    modport slave (
        input  iReq, instrAddr, dReq, dataAddr, writeData, we, memReady, memRdata,
        output instr, iValid, readData, dValid, memReq, memAddr, memWdata, memWe,
        output busErr, errSticky
    );

    modport master (
        output iReq, instrAddr, dReq, dataAddr, writeData, we, memReady, memRdata,
        input  instr, iValid, readData, dValid, memReq, memAddr, memWdata, memWe,
        input  busErr, errSticky
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fair two-port arbiter for a single-port unified memory (instruction fetch vs. load/store),
// with registered outputs and a watchdog that aborts accesses the memory never completes.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h0000_0013);
    localparam logic [31:0]       TO_LAST  = 32'(TIMEOUT - 1);
    localparam logic              GRANT_I  = 1'b0;
    localparam logic              GRANT_D  = 1'b1;

    state_t            state_r, state_nxt_s;
    logic              last_grant_r, last_grant_nxt_s;
    logic [31:0]       count_r, count_nxt_s;
    logic              mem_req_r, mem_req_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic              mem_we_r, mem_we_nxt_s;
    logic [DATA_W-1:0] instr_r, instr_nxt_s;
    logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
    logic              i_valid_r, i_valid_nxt_s;
    logic              d_valid_r, d_valid_nxt_s;
    logic              bus_err_r, bus_err_nxt_s;
    logic              err_sticky_r, err_sticky_nxt_s;
    logic              grant_i_s, grant_d_s, abort_s;

    // On a tie the port that lost the previous grant wins.
    assign grant_i_s = bus.iReq && (!bus.dReq || (last_grant_r == GRANT_D));
    assign grant_d_s = bus.dReq && (!bus.iReq || (last_grant_r == GRANT_I));
    assign abort_s   = !bus.memReady && (TIMEOUT != 0) && (count_r == TO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_i_s) begin
                    state_nxt_s = BUSY_I;
                end else if (grant_d_s) begin
                    state_nxt_s = BUSY_D;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.memReady || abort_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of every registered output and of the grant/watchdog bookkeeping.
    always_comb begin
        last_grant_nxt_s = last_grant_r;
        count_nxt_s      = count_r;
        mem_req_nxt_s    = mem_req_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        mem_we_nxt_s     = mem_we_r;
        instr_nxt_s      = instr_r;
        rdata_nxt_s      = rdata_r;
        err_sticky_nxt_s = err_sticky_r;
        i_valid_nxt_s    = 1'b0;
        d_valid_nxt_s    = 1'b0;
        bus_err_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_i_s) begin
                    mem_req_nxt_s    = 1'b1;
                    mem_addr_nxt_s   = bus.instrAddr;
                    mem_we_nxt_s     = 1'b0;
                    last_grant_nxt_s = GRANT_I;
                    count_nxt_s      = 32'd0;
                end else if (grant_d_s) begin
                    mem_req_nxt_s    = 1'b1;
                    mem_addr_nxt_s   = bus.dataAddr;
                    mem_wdata_nxt_s  = bus.writeData;
                    mem_we_nxt_s     = bus.we;
                    last_grant_nxt_s = GRANT_D;
                    count_nxt_s      = 32'd0;
                end else begin
                    mem_req_nxt_s = 1'b0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.memReady) begin
                    mem_req_nxt_s = 1'b0;
                    if (state_r == BUSY_I) begin
                        i_valid_nxt_s = 1'b1;
                        instr_nxt_s   = bus.memRdata;
                    end else begin
                        d_valid_nxt_s = 1'b1;
                        rdata_nxt_s   = mem_we_r ? rdata_r : bus.memRdata;
                    end
                end else if (abort_s) begin
                    mem_req_nxt_s    = 1'b0;
                    bus_err_nxt_s    = 1'b1;
                    err_sticky_nxt_s = 1'b1;
                    if (state_r == BUSY_I) begin
                        i_valid_nxt_s = 1'b1;
                        instr_nxt_s   = NOP_INSN;
                    end else begin
                        d_valid_nxt_s = 1'b1;
                        rdata_nxt_s   = {DATA_W{1'b0}};
                    end
                end else begin
                    count_nxt_s = count_r + 32'd1;
                end
            end
            default: mem_req_nxt_s = 1'b0;
        endcase
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= GRANT_D;
            count_r      <= 32'd0;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            mem_we_r     <= 1'b0;
            instr_r      <= {DATA_W{1'b0}};
            rdata_r      <= {DATA_W{1'b0}};
            i_valid_r    <= 1'b0;
            d_valid_r    <= 1'b0;
            bus_err_r    <= 1'b0;
            err_sticky_r <= 1'b0;
        end else begin
            last_grant_r <= last_grant_nxt_s;
            count_r      <= count_nxt_s;
            mem_req_r    <= mem_req_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            instr_r      <= instr_nxt_s;
            rdata_r      <= rdata_nxt_s;
            i_valid_r    <= i_valid_nxt_s;
            d_valid_r    <= d_valid_nxt_s;
            bus_err_r    <= bus_err_nxt_s;
            err_sticky_r <= err_sticky_nxt_s;
        end
    end

    assign bus.memReq    = mem_req_r;
    assign bus.memAddr   = mem_addr_r;
    assign bus.memWdata  = mem_wdata_r;
    assign bus.memWe     = mem_we_r;
    assign bus.instr     = instr_r;
    assign bus.readData  = rdata_r;
    assign bus.iValid    = i_valid_r;
    assign bus.dValid    = d_valid_r;
    assign bus.busErr    = bus_err_r;
    assign bus.errSticky = err_sticky_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a 32-word memory model answers the arbiter while a
// reference memory image and expected-output tracker predict every result.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem [32];
    logic [31:0] exp_mem [32];
    logic [31:0] exp_instr;
    logic [31:0] exp_rdata;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Issue one request (called at a negedge with the arbiter idle) and play the memory:
    // memReady is raised in the memReq cycle numbered 'delay' (never if delay < 0).
    // Returns at the negedge right after memReq falls, with all requests dropped.
    task automatic access(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit wr, input int delay, output int req_cyc, output bit stable,
                          output logic [31:0] s_addr, output logic [31:0] s_wdata,
                          output logic s_we, output logic v_i, output logic v_d,
                          output logic err, output logic [31:0] o_instr,
                          output logic [31:0] o_rdata);
        req_cyc = 0;
        stable  = 1'b1;
        s_addr  = 32'd0;
        s_wdata = 32'd0;
        s_we    = 1'b0;
        if (is_d) begin
            bus.dReq = 1'b1; bus.dataAddr = addr; bus.writeData = wdata; bus.we = wr;
        end else begin
            bus.iReq = 1'b1; bus.instrAddr = addr;
        end
        @(negedge clk);
        while (bus.memReq === 1'b1 && req_cyc < 64) begin
            if (req_cyc == 0) begin
                s_addr = bus.memAddr; s_wdata = bus.memWdata; s_we = bus.memWe;
            end else if (bus.memAddr !== s_addr || bus.memWdata !== s_wdata || bus.memWe !== s_we) begin
                stable = 1'b0;
            end
            if (delay >= 0 && req_cyc == delay) begin
                bus.memReady = 1'b1;
                bus.memRdata = mem[bus.memAddr[6:2]];
                if (bus.memWe) mem[bus.memAddr[6:2]] = bus.memWdata;
            end else begin
                bus.memRdata = $urandom;
            end
            req_cyc++;
            @(negedge clk);
            bus.memReady = 1'b0;
            bus.memRdata = $urandom;
        end
        v_i = bus.iValid; v_d = bus.dValid; err = bus.busErr;
        o_instr = bus.instr; o_rdata = bus.readData;
        bus.iReq = 1'b0; bus.dReq = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.memReq !== 1'b0 || bus.iValid !== 1'b0 || bus.dValid !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl: got req/iv/dv %b%b%b expected 000", bus.memReq, bus.iValid, bus.dValid); end
        n_cmp++; if ({bus.memAddr, bus.memWdata, bus.memWe} !== 65'd0) begin
            n_err++; $display("FAIL reset_mem: got %h/%h/%b expected zeros", bus.memAddr, bus.memWdata, bus.memWe); end
        n_cmp++; if ({bus.instr, bus.readData, bus.busErr, bus.errSticky} !== 66'd0) begin
            n_err++; $display("FAIL reset_data: got %h/%h/%b/%b expected zeros", bus.instr, bus.readData, bus.busErr, bus.errSticky); end
        reset = 1'b0;
        bus.memReady = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.memReq !== 1'b0 || bus.iValid !== 1'b0 || bus.dValid !== 1'b0) begin
            n_err++; $display("FAIL idle_ready_ignored: got req/iv/dv %b%b%b expected 000", bus.memReq, bus.iValid, bus.dValid); end
        bus.memReady = 1'b0;
        exp_instr = 32'd0; exp_rdata = 32'd0;
    endtask

    task automatic test_fetch();
        int rc; bit st; logic [31:0] sa, sw, oi, od; logic swe, vi, vd, er;
        mem[4] = 32'h0000_2083; exp_mem[4] = 32'h0000_2083;
        access(1'b0, 32'h10, 32'd0, 1'b0, 0, rc, st, sa, sw, swe, vi, vd, er, oi, od);
        exp_instr = 32'h0000_2083;
        n_cmp++; if (rc !== 1) begin n_err++; $display("FAIL fetch_req_cycles: got %0d expected 1", rc); end
        n_cmp++; if (sa !== 32'h10 || swe !== 1'b0) begin n_err++; $display("FAIL fetch_addr: got %h we %b expected 00000010 we 0", sa, swe); end
        n_cmp++; if (vi !== 1'b1 || vd !== 1'b0 || er !== 1'b0) begin n_err++; $display("FAIL fetch_valid: got iv/dv/err %b%b%b expected 100", vi, vd, er); end
        n_cmp++; if (oi !== exp_instr) begin n_err++; $display("FAIL fetch_instr: got %h expected %h", oi, exp_instr); end
        @(negedge clk);
        n_cmp++; if (bus.iValid !== 1'b0 || bus.instr !== exp_instr) begin
            n_err++; $display("FAIL fetch_pulse_hold: got iv %b instr %h expected 0 %h", bus.iValid, bus.instr, exp_instr); end
    endtask

    task automatic test_store_load();
        int rc; bit st; logic [31:0] sa, sw, oi, od; logic swe, vi, vd, er;
        access(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1, 0, rc, st, sa, sw, swe, vi, vd, er, oi, od);
        exp_mem[16] = 32'hDEAD_BEEF;
        n_cmp++; if (swe !== 1'b1 || sw !== 32'hDEAD_BEEF || sa !== 32'h40) begin
            n_err++; $display("FAIL store_bus: got we %b data %h addr %h expected 1 deadbeef 00000040", swe, sw, sa); end
        n_cmp++; if (vd !== 1'b1 || vi !== 1'b0 || od !== exp_rdata) begin
            n_err++; $display("FAIL store_done: got dv %b iv %b rdata %h expected 1 0 %h", vd, vi, od, exp_rdata); end
        access(1'b1, 32'h40, 32'h1111_2222, 1'b0, 1, rc, st, sa, sw, swe, vi, vd, er, oi, od);
        exp_rdata = exp_mem[16];
        n_cmp++; if (rc !== 2 || swe !== 1'b0) begin n_err++; $display("FAIL load_bus: got cycles %0d we %b expected 2 0", rc, swe); end
        n_cmp++; if (vd !== 1'b1 || od !== exp_rdata) begin n_err++; $display("FAIL load_data: got dv %b rdata %h expected 1 %h", vd, od, exp_rdata); end
    endtask

    task automatic test_wait_states();
        int rc; bit st; logic [31:0] sa, sw, oi, od; logic swe, vi, vd, er;
        access(1'b0, 32'h20, 32'd0, 1'b0, 3, rc, st, sa, sw, swe, vi, vd, er, oi, od);
        exp_instr = exp_mem[8];
        n_cmp++; if (rc !== 4 || st !== 1'b1) begin n_err++; $display("FAIL wait_req: got cycles %0d stable %b expected 4 1", rc, st); end
        n_cmp++; if (vi !== 1'b1 || er !== 1'b0 || oi !== exp_instr) begin
            n_err++; $display("FAIL wait_done: got iv %b err %b instr %h expected 1 0 %h", vi, er, oi, exp_instr); end
    endtask

    task automatic test_random();
        int rc; bit st; logic [31:0] sa, sw, oi, od; logic swe, vi, vd, er;
        for (int t = 0; t < 24; t++) begin
            bit is_d; bit wr; int idx; int dl; logic [31:0] wd;
            is_d = 1'($urandom_range(0, 1));
            wr   = is_d && (1'($urandom_range(0, 1)) == 1'b1);
            idx  = $urandom_range(0, 31);
            dl   = $urandom_range(0, 3);
            wd   = $urandom;
            access(is_d, 32'(idx * 4), wd, wr, dl, rc, st, sa, sw, swe, vi, vd, er, oi, od);
            if (!is_d) exp_instr = exp_mem[idx];
            else if (!wr) exp_rdata = exp_mem[idx];
            else exp_mem[idx] = wd;
            n_cmp++; if (rc !== dl + 1 || st !== 1'b1) begin
                n_err++; $display("FAIL rnd_req[%0d]: got cycles %0d stable %b expected %0d 1", t, rc, st, dl + 1); end
            n_cmp++; if (sa !== 32'(idx * 4) || swe !== wr) begin
                n_err++; $display("FAIL rnd_addr[%0d]: got %h we %b expected %h we %b", t, sa, swe, 32'(idx * 4), wr); end
            n_cmp++; if (vi !== !is_d || vd !== is_d || er !== 1'b0) begin
                n_err++; $display("FAIL rnd_valid[%0d]: got iv/dv/err %b%b%b expected %b%b0", t, vi, vd, er, !is_d, is_d); end
            n_cmp++; if (oi !== exp_instr || od !== exp_rdata) begin
                n_err++; $display("FAIL rnd_data[%0d]: got %h/%h expected %h/%h", t, oi, od, exp_instr, exp_rdata); end
            if (wr) begin
                n_cmp++; if (sw !== wd) begin n_err++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", t, sw, wd); end
            end
        end
    endtask

    task automatic test_drop_request();
        bus.iReq = 1'b1; bus.instrAddr = 32'h08;
        @(negedge clk);
        n_cmp++; if (bus.memReq !== 1'b1) begin n_err++; $display("FAIL drop_req: got memReq %b expected 1", bus.memReq); end
        bus.iReq = 1'b0; bus.instrAddr = 32'hFC;
        bus.memReady = 1'b1; bus.memRdata = mem[2];
        @(negedge clk);
        bus.memReady = 1'b0;
        exp_instr = exp_mem[2];
        n_cmp++; if (bus.iValid !== 1'b1 || bus.instr !== exp_instr) begin
            n_err++; $display("FAIL drop_done: got iv %b instr %h expected 1 %h", bus.iValid, bus.instr, exp_instr); end
    endtask

    task automatic test_tie();
        logic [31:0] grants [$];
        int nvi = 0; int nvd = 0; int overlap = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.instrAddr = 32'h100; bus.dataAddr = 32'h200; bus.we = 1'b0;
        bus.memReady = 1'b1; bus.memRdata = 32'h1234_5678;
        bus.iReq = 1'b1; bus.dReq = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.memReq === 1'b1) grants.push_back(bus.memAddr);
            if (bus.iValid === 1'b1) nvi++;
            if (bus.dValid === 1'b1) nvd++;
            if (bus.iValid === 1'b1 && bus.dValid === 1'b1) overlap++;
        end
        bus.iReq = 1'b0; bus.dReq = 1'b0;
        @(negedge clk);
        bus.memReady = 1'b0;
        exp_instr = 32'h1234_5678; exp_rdata = 32'h1234_5678;
        n_cmp++; if (grants.size() !== 20) begin n_err++; $display("FAIL tie_grants: got %0d expected 20", grants.size()); end
        for (int k = 0; k < 8 && k < grants.size(); k++) begin
            logic [31:0] want;
            want = (k % 2 == 0) ? 32'h100 : 32'h200;
            n_cmp++; if (grants[k] !== want) begin n_err++; $display("FAIL tie_order[%0d]: got %h expected %h", k, grants[k], want); end
        end
        n_cmp++; if (nvi !== 10 || nvd !== 10 || overlap !== 0) begin
            n_err++; $display("FAIL tie_valids: got i %0d d %0d both %0d expected 10 10 0", nvi, nvd, overlap); end
    endtask

    task automatic test_timeout();
        int rc; bit st; logic [31:0] sa, sw, oi, od; logic swe, vi, vd, er;
        access(1'b0, 32'h30, 32'd0, 1'b0, -1, rc, st, sa, sw, swe, vi, vd, er, oi, od);
        n_cmp++; if (rc !== TO) begin n_err++; $display("FAIL to_req_cycles: got %0d expected %0d", rc, TO); end
        n_cmp++; if (vi !== 1'b1 || er !== 1'b1 || oi !== 32'h0000_0013) begin
            n_err++; $display("FAIL to_fetch: got iv %b err %b instr %h expected 1 1 00000013", vi, er, oi); end
        n_cmp++; if (bus.errSticky !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b expected 1", bus.errSticky); end
        access(1'b1, 32'h34, 32'd0, 1'b0, -1, rc, st, sa, sw, swe, vi, vd, er, oi, od);
        n_cmp++; if (rc !== TO || vd !== 1'b1 || er !== 1'b1 || od !== 32'd0) begin
            n_err++; $display("FAIL to_load: got cycles %0d dv %b err %b rdata %h expected %0d 1 1 0", rc, vd, er, od, TO); end
        access(1'b0, 32'h38, 32'd0, 1'b0, 2, rc, st, sa, sw, swe, vi, vd, er, oi, od);
        n_cmp++; if (er !== 1'b0 || oi !== exp_mem[14] || bus.errSticky !== 1'b1) begin
            n_err++; $display("FAIL to_after: got err %b instr %h sticky %b expected 0 %h 1", er, oi, bus.errSticky, exp_mem[14]); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (bus.errSticky !== 1'b0) begin n_err++; $display("FAIL to_sticky_clear: got %b expected 0", bus.errSticky); end
    endtask

    task automatic test_reset_mid();
        bus.dReq = 1'b1; bus.dataAddr = 32'h44; bus.we = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.memReq !== 1'b1) begin n_err++; $display("FAIL mid_busy: got memReq %b expected 1", bus.memReq); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.memReq, bus.iValid, bus.dValid, bus.busErr, bus.errSticky, bus.memWe} !== 6'd0) begin
            n_err++; $display("FAIL mid_ctrl: got %b%b%b%b%b%b expected 000000", bus.memReq, bus.iValid, bus.dValid, bus.busErr, bus.errSticky, bus.memWe); end
        n_cmp++; if ({bus.memAddr, bus.memWdata, bus.instr, bus.readData} !== 128'd0) begin
            n_err++; $display("FAIL mid_data: got %h %h %h %h expected zeros", bus.memAddr, bus.memWdata, bus.instr, bus.readData); end
        reset = 1'b0;
        bus.iReq = 1'b1; bus.instrAddr = 32'h0C; bus.dReq = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.memReq !== 1'b1 || bus.memAddr !== 32'h0C) begin
            n_err++; $display("FAIL mid_tie: got req %b addr %h expected 1 0000000c", bus.memReq, bus.memAddr); end
        bus.memReady = 1'b1; bus.memRdata = 32'h0;
        @(negedge clk);
        bus.iReq = 1'b0; bus.dReq = 1'b0; bus.memReady = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        bus.iReq = 1'b0; bus.instrAddr = 32'd0; bus.dReq = 1'b0; bus.dataAddr = 32'd0;
        bus.writeData = 32'd0; bus.we = 1'b0; bus.memReady = 1'b0; bus.memRdata = 32'd0;
        for (int i = 0; i < 32; i++) begin
            logic [31:0] v;
            v = $urandom;
            mem[i] = v;
            exp_mem[i] = v;
        end
        test_reset();
        test_fetch();
        test_store_load();
        test_wait_states();
        test_random();
        test_drop_request();
        test_tie();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
